// File: rtl/qsn_merge_pipe_len3.sv
// qsn_merge_pipe_len3: lane merge of the QSN left/right networks
// followed by a 2-entry valid/ready output buffer.
module qsn_merge_pipe_len3 #(
    parameter int PC    = 3,
    parameter int MSG_W = 4
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC*MSG_W-1:0] left_in,
    input  logic [PC*MSG_W-1:0] right_in,
    input  logic [1:0]          shift,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC*MSG_W-1:0] out_data,
    output logic                out_last,
    output logic                out_err,
    output logic                shift_err
);

    logic [PC*MSG_W-1:0] ent_data [2];
    logic [1:0]          ent_last;
    logic [1:0]          ent_err;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;

    logic [PC*MSG_W-1:0] merged;
    logic                shift_bad;
    logic                push;
    logic                pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign shift_bad = (int'(shift) >= PC);

    assign out_data = ent_data[rd_ptr];
    assign out_last = ent_last[rd_ptr];
    assign out_err  = ent_err[rd_ptr];

    // Lane select: low lanes come from the left network, the top
    // `shift` lanes from the right one; illegal shifts fall back to left.
    always_comb begin
        merged = left_in;
        for (int i = 0; i < PC; i++) begin
            if (!shift_bad && (i >= PC - int'(shift))) begin
                merged[i*MSG_W +: MSG_W] = right_in[i*MSG_W +: MSG_W];
            end
        end
    end

    // FIFO storage, pointers, occupancy and the sticky error flag.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ent_data[0] <= '0;
            ent_data[1] <= '0;
            ent_last    <= '0;
            ent_err     <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            shift_err   <= 1'b0;
        end else begin
            if (push) begin
                ent_data[wr_ptr] <= merged;
                ent_last[wr_ptr] <= in_last;
                ent_err[wr_ptr]  <= shift_bad;
                wr_ptr           <= ~wr_ptr;
                if (shift_bad) begin
                    shift_err <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: doc/qsn_merge_pipe_len3.md
# qsn_merge_pipe_len3

Registered merge-and-buffer stage that sits directly downstream of the length-3 QSN left/right shift networks in the partial message-passing datapath. Each accepted beat combines the two network outputs lane-by-lane according to the beat's shift factor. The merged vector is pushed into a 2-entry output FIFO with valid/ready handshakes on both sides. The block decouples the combinational shifter from the layered-decoder consumer and flags out-of-range shift factors.

## Interface

Parameters:
- PC, 3, lanes per vector (submatrix size); the shift-factor width is fixed at 2 bits for PC=3.
- MSG_W, 4, bits per lane (quantisation size).

Ports:
- sys_clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- left_in  in  PC*MSG_W  left-network output; lane i = bits [i*MSG_W +: MSG_W].
- right_in  in  PC*MSG_W  right-network output, same lane packing as left_in.
- shift  in  2  shift factor for this beat; legal range 0..PC-1.
- in_last  in  1  last beat of the current layer; carried through unchanged.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  PC*MSG_W  merged vector at the FIFO head.
- out_last  out  1  in_last of the head beat.
- out_err  out  1  the head beat had an illegal shift.
- shift_err  out  1  sticky flag; set by any accepted illegal shift, cleared only by rst.

## Operation

- Merge rule per lane i, 0..PC-1:
  - lane i takes left_in lane i when i < PC - shift;
  - otherwise lane i takes right_in lane i.
- Illegal shift (shift >= PC, i.e. 3):
  - all lanes take left_in;
  - the entry's err bit is set;
  - shift_err is set on the accepting edge.
- Push: in_valid && in_ready at a rising edge.
  - Writes {merged, in_last, err} to FIFO entry wr_ptr.
  - wr_ptr toggles; count increments.
- Pop: out_valid && out_ready at a rising edge.
  - rd_ptr toggles; count decrements.
- FIFO depth is 2, held in two entries with 1-bit wr_ptr/rd_ptr and a 2-bit count (0..2).
- in_ready = (count != 2). It depends only on registered state, never on out_ready.
- out_valid = (count != 0). out_data, out_last and out_err are driven from entry rd_ptr.
- Simultaneous push and pop:
  - allowed when count is 1;
  - count stays unchanged and both pointers toggle.
- At count 2, in_ready is low, so there is no push; a pop that cycle leaves count at 1.
- At count 0 there is no pop; out_valid is low and out_ready is ignored.
- Inputs are sampled only on a push edge. Data presented while in_ready is low is not captured.

## Timing

- Reset (rst high at an edge) sets: count=0, wr_ptr=0, rd_ptr=0, both entries cleared to zero, shift_err=0.
- Resulting outputs after reset: in_ready=1, out_valid=0, out_data=0, out_last=0, out_err=0.
- Reset mid-transfer discards both buffered entries. There is no pop or push on the reset edge, even if the handshakes are high.
- Latency: a beat pushed at edge N appears on out_data with out_valid high in the cycle after edge N when the FIFO was empty. When beats are queued, they leave in push order.
- Throughput: one beat per cycle sustained while out_ready is held high.
- The merge path is combinational from left_in/right_in/shift into the FIFO write port. There is no stage between the network outputs and the FIFO.
- Beat ordering, last and err bits are never reordered or dropped.

## Test plan

Vectors are written lane2..lane0. Base inputs: left_in=12'hCBA, right_in=12'h321, PC=3, MSG_W=4.

- **Merge rule.** Push 4 beats with shift 0, 1, 2, 3 and out_ready=1.
  - Required out_data sequence: 12'hCBA, 12'h3BA, 12'h32A, 12'hCBA.
  - out_err: 0, 0, 0, 1.
  - shift_err: rises the cycle after the 4th push and stays 1.
- **Backpressure fill.** out_ready=0; push shift=1 then shift=2.
  - After the 2nd push: in_ready=0, out_valid=1, out_data=12'h3BA.
  - A 3rd beat held on the inputs is not captured.
  - Raise out_ready: pops yield 12'h3BA then 12'h32A, and in_ready returns to 1 after the first pop.
- **Simultaneous push/pop at count 1.** Hold in_valid=1 and out_ready=1 for 6 cycles with in_last=1 on beat 6.
  - count stays 1, with one output per cycle in order.
  - out_last=1 only on the 6th output.
- **Empty pop.** out_ready=1, in_valid=0 from reset.
  - out_valid stays 0 and count stays 0, with no underflow.
- **Reset mid-operation.** Fill both entries (one with shift=3), then assert rst for one cycle.
  - The next cycle shows: out_valid=0, out_data=0, out_err=0, shift_err=0, in_ready=1.
  - A fresh push with shift=0 yields 12'hCBA.
